sequence_scheduler: RTL and testbench

Owns the Simon Says colour sequence and its timing, and is sequenced by the game FSM through single-cycle command strobes. It generates colours from a 16-bit LFSR that free-runs during the seeding phase, and stores up to MAX_ROUNDS 2-bit colours. On command it plays the stored sequence back with speed-scaled on/off pulses, then checks player moves against the sequence.

---
 rtl/sched_pkg.sv | 33 +++
 rtl/lfsr16.sv | 31 +++
 rtl/sequence_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_sequence_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared types, constants and helpers for the sequence scheduler
package sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEEDING,
        ST_READY,
        ST_SHOW_ON,
        ST_SHOW_OFF
    } sched_state_t;

    // Single decoded command after priority resolution
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_SEED_RST,
        CMD_START_RNG,
        CMD_ADD_CLR,
        CMD_INC_SPEED,
        CMD_SHOW,
        CMD_CHECK
    } sched_cmd_t;

    typedef logic [1:0] colour_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [2:0]  SPEED_MAX = 3'd7;

    // Colour index to one-hot lamp / button bit
    function automatic logic [3:0] onehot4(input colour_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR with seed load and step enable
module lfsr16
    import sched_pkg::*;
#(
    parameter logic [15:0] MASK = LFSR_MASK
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] seed,
    input  logic        load,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] q_next;

    // Right shift; feed the dropped LSB back through the tap mask
    always_comb begin
        q_next = {1'b0, q[15:1]} ^ (q[0] ? MASK : 16'h0000);
    end

    // Reset and load both return to the seed; otherwise advance on step
    always_ff @(posedge clk) begin
        if (!resetn || load) begin
            q <= seed;
        end else if (step) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/sequence_scheduler.sv
// rtl/sequence_scheduler.sv - Simon Says colour sequence store, playback timing and move checking
module sequence_scheduler
    import sched_pkg::*;
#(
    parameter int          MAX_ROUNDS = 32,
    parameter int          BASE_TICKS = 25_000_000,
    parameter int          SPEED_STEP = 3_125_000,
    parameter int          MIN_TICKS  = 6_250_000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_seed_rst,
    input  logic       cmd_start_rng,
    input  logic       cmd_add_clr,
    input  logic       cmd_inc_speed,
    input  logic       cmd_show,
    input  logic       cmd_check,
    input  logic [3:0] player_input,
    output logic [3:0] show_colour,
    output logic       pulse,
    output logic [5:0] show_left,
    output logic [5:0] moves_left,
    output logic [5:0] current_round,
    output logic       result_valid,
    output logic       result,
    output logic       busy
);

    localparam int IDX_W = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;

    sched_state_t state_q, state_d;
    sched_cmd_t   cmd;

    logic [15:0]      lfsr_q;
    logic             lfsr_step;
    logic             lfsr_unused;
    logic [2:0]       speed_level;
    logic [31:0]      timer_q;
    logic [31:0]      p_q;
    logic [31:0]      on_ticks;
    int               p_signed;
    logic             timer_done;
    logic [IDX_W-1:0] play_idx;
    logic [IDX_W-1:0] chk_idx;
    logic [IDX_W-1:0] rd_idx;
    colour_t          rd_colour;
    colour_t          mem [MAX_ROUNDS];

    logic do_add;
    logic do_show;
    logic do_check;

    // Only the upper LFSR bits are unused here; colours take the low two
    assign lfsr_unused = ^lfsr_q[15:2];

    // Priority-resolve the strobes; while playing only seed_rst survives
    always_comb begin
        cmd = CMD_NONE;
        if (cmd_seed_rst) begin
            cmd = CMD_SEED_RST;
        end else if (!busy) begin
            if (cmd_start_rng)      cmd = CMD_START_RNG;
            else if (cmd_add_clr)   cmd = CMD_ADD_CLR;
            else if (cmd_inc_speed) cmd = CMD_INC_SPEED;
            else if (cmd_show)      cmd = CMD_SHOW;
            else if (cmd_check)     cmd = CMD_CHECK;
        end
    end

    assign do_add   = (cmd == CMD_ADD_CLR) && (state_q == ST_READY) &&
                      (current_round != 6'(MAX_ROUNDS));
    assign do_show  = (cmd == CMD_SHOW) && (state_q == ST_READY) && (show_left != 6'd0);
    assign do_check = (cmd == CMD_CHECK) && (state_q == ST_READY);

    // LFSR free-runs while seeding (not on the freeze cycle) and steps once per appended colour
    assign lfsr_step = ((state_q == ST_SEEDING) && (cmd != CMD_SEED_RST) &&
                        (cmd != CMD_START_RNG)) || do_add;

    lfsr16 #(
        .MASK   (LFSR_MASK)
    ) u_lfsr (
        .clk    (clk),
        .resetn (reset),
        .seed   (LFSR_SEED),
        .load   (cmd == CMD_SEED_RST),
        .step   (lfsr_step),
        .q      (lfsr_q)
    );

    // On-phase length in signed arithmetic so high speed levels clamp instead of wrapping
    always_comb begin
        p_signed = BASE_TICKS - int'(speed_level) * SPEED_STEP;
        on_ticks = (p_signed < MIN_TICKS) ? 32'(MIN_TICKS) : 32'(p_signed);
    end

    assign timer_done = (timer_q == 32'd0);
    assign busy       = (state_q == ST_SHOW_ON) || (state_q == ST_SHOW_OFF);
    assign pulse      = (state_q == ST_SHOW_OFF) && timer_done;

    // Playback and check share the single read port; they never overlap
    assign rd_idx      = busy ? play_idx : chk_idx;
    assign rd_colour   = mem[rd_idx];
    assign show_colour = (state_q == ST_SHOW_ON) ? onehot4(rd_colour) : 4'b0000;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; seed_rst wins from every state, including mid-playback
    always_comb begin
        state_d = state_q;
        if (cmd == CMD_SEED_RST) begin
            state_d = ST_SEEDING;
        end else begin
            case (state_q)
                ST_SEEDING:  if (cmd == CMD_START_RNG) state_d = ST_READY;
                ST_READY:    if (do_show) state_d = ST_SHOW_ON;
                ST_SHOW_ON:  if (timer_done) state_d = ST_SHOW_OFF;
                ST_SHOW_OFF: if (timer_done) state_d = ST_READY;
                default:     state_d = state_q;
            endcase
        end
    end

    // Sequence storage; contents are don't-care after reset so no reset term
    always_ff @(posedge clk) begin
        if (do_add) begin
            mem[current_round[IDX_W-1:0]] <= lfsr_q[1:0];
        end
    end

    // Round counters, speed, phase timer and check result
    always_ff @(posedge clk) begin
        if (!reset) begin
            current_round <= 6'd0;
            show_left     <= 6'd0;
            moves_left    <= 6'd0;
            speed_level   <= 3'd0;
            play_idx      <= '0;
            chk_idx       <= '0;
            timer_q       <= 32'd0;
            p_q           <= 32'd0;
            result_valid  <= 1'b0;
            result        <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (cmd == CMD_SEED_RST) begin
                current_round <= 6'd0;
                show_left     <= 6'd0;
                moves_left    <= 6'd0;
                speed_level   <= 3'd0;
                play_idx      <= '0;
                chk_idx       <= '0;
                timer_q       <= 32'd0;
                result        <= 1'b0;
            end else begin
                if (do_add) begin
                    current_round <= current_round + 6'd1;
                    show_left     <= current_round + 6'd1;
                    moves_left    <= current_round + 6'd1;
                    play_idx      <= '0;
                    chk_idx       <= '0;
                end

                if ((cmd == CMD_INC_SPEED) && (speed_level != SPEED_MAX)) begin
                    speed_level <= speed_level + 3'd1;
                end

                // Timer counts down to zero in each phase; the off phase is a quarter of P
                if (do_show) begin
                    p_q     <= on_ticks;
                    timer_q <= on_ticks - 32'd1;
                end else if ((state_q == ST_SHOW_ON) && timer_done) begin
                    timer_q <= (p_q >> 2) - 32'd1;
                end else if (busy && !timer_done) begin
                    timer_q <= timer_q - 32'd1;
                end

                if (pulse) begin
                    show_left <= show_left - 6'd1;
                    play_idx  <= play_idx + 1'b1;
                end

                if (do_check) begin
                    result_valid <= 1'b1;
                    if (moves_left == 6'd0) begin
                        result <= 1'b0;
                    end else if (player_input == onehot4(rd_colour)) begin
                        result     <= 1'b1;
                        moves_left <= moves_left - 6'd1;
                        chk_idx    <= chk_idx + 1'b1;
                    end else begin
                        result <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sequence_scheduler.sv
// tb/tb_sequence_scheduler.sv - directed self-checking bench for sequence_scheduler
module tb_sequence_scheduler;
    import sched_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_seed_rst, cmd_start_rng, cmd_add_clr, cmd_inc_speed, cmd_show, cmd_check;
    logic [3:0] player_input;
    logic [3:0] show_colour;
    logic       pulse;
    logic [5:0] show_left, moves_left, current_round;
    logic       result_valid, result, busy;

    int n_cmp = 0;
    int n_bad = 0;

    colour_t col [3];
    colour_t m0, m1;
    logic [15:0] s;

    always #5 clk = ~clk;

    sequence_scheduler #(
        .MAX_ROUNDS (32),
        .BASE_TICKS (16),
        .SPEED_STEP (4),
        .MIN_TICKS  (4),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_seed_rst  (cmd_seed_rst),
        .cmd_start_rng (cmd_start_rng),
        .cmd_add_clr   (cmd_add_clr),
        .cmd_inc_speed (cmd_inc_speed),
        .cmd_show      (cmd_show),
        .cmd_check     (cmd_check),
        .player_input  (player_input),
        .show_colour   (show_colour),
        .pulse         (pulse),
        .show_left     (show_left),
        .moves_left    (moves_left),
        .current_round (current_round),
        .result_valid  (result_valid),
        .result        (result),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference Galois LFSR: state after n steps from the seed
    function automatic logic [15:0] lfsr_model(input int n);
        logic [15:0] v;
        v = 16'hACE1;
        for (int i = 0; i < n; i++) begin
            v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One playback step: lamp on for 'on' cycles, dark for 'off', pulse on the very last
    task automatic play(input logic [3:0] lamp, input int on, input int off,
                        input logic [5:0] left_after, input bit poke);
        cmd_show = 1'b1;
        tick();
        cmd_show = 1'b0;
        for (int c = 1; c <= on + off; c++) begin
            chk("show_colour", 32'(show_colour), (c <= on) ? 32'(lamp) : 32'd0);
            chk("pulse", 32'(pulse), (c == on + off) ? 32'd1 : 32'd0);
            chk("busy", 32'(busy), 32'd1);
            if (poke && c == 5) cmd_show = 1'b1;
            tick();
            cmd_show = 1'b0;
        end
        chk("show_left_after", 32'(show_left), 32'(left_after));
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic do_check(input logic [3:0] pin);
        player_input = pin;
        cmd_check    = 1'b1;
        tick();
        cmd_check    = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        cmd_seed_rst  = 1'b0;
        cmd_start_rng = 1'b0;
        cmd_add_clr   = 1'b0;
        cmd_inc_speed = 1'b0;
        cmd_show      = 1'b0;
        cmd_check     = 1'b0;
        player_input  = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            s = lfsr_model(10 + i);
            col[i] = s[1:0];
        end
        s  = lfsr_model(0);
        m0 = s[1:0];
        s  = lfsr_model(1);
        m1 = s[1:0];

        // Reset state
        tick();
        tick();
        reset = 1'b1;
        chk("rst_show_colour", 32'(show_colour), 32'd0);
        chk("rst_pulse", 32'(pulse), 32'd0);
        chk("rst_show_left", 32'(show_left), 32'd0);
        chk("rst_moves_left", 32'(moves_left), 32'd0);
        chk("rst_current_round", 32'(current_round), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        cmd_show = 1'b1;
        tick();
        cmd_show = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("idle_show_busy", 32'(busy), 32'd0);
            chk("idle_show_pulse", 32'(pulse), 32'd0);
            tick();
        end

        // Seeding: 10 free-run cycles, freeze, append three colours
        cmd_seed_rst = 1'b1;
        tick();
        cmd_seed_rst = 1'b0;
        repeat (10) tick();
        cmd_start_rng = 1'b1;
        tick();
        cmd_start_rng = 1'b0;
        cmd_add_clr = 1'b1;
        repeat (3) tick();
        cmd_add_clr = 1'b0;
        chk("seed_current_round", 32'(current_round), 32'd3);
        chk("seed_show_left", 32'(show_left), 32'd3);
        chk("seed_moves_left", 32'(moves_left), 32'd3);

        // Playback at speed 0 (on 16, off 4), with an ignored cmd_show mid-step
        play(onehot4(col[0]), 16, 4, 6'd2, 1'b1);

        // Speed 2 -> P=8, off 2
        cmd_inc_speed = 1'b1;
        repeat (2) tick();
        cmd_inc_speed = 1'b0;
        play(onehot4(col[1]), 8, 2, 6'd1, 1'b0);

        // Seven more: saturates at 7 -> P clamps to 4, off 1 (a wrap would give P=12)
        cmd_inc_speed = 1'b1;
        repeat (7) tick();
        cmd_inc_speed = 1'b0;
        play(onehot4(col[2]), 4, 1, 6'd0, 1'b0);
        cmd_inc_speed = 1'b1;
        repeat (2) tick();
        cmd_inc_speed = 1'b0;

        // cmd_show with nothing left to play
        cmd_show = 1'b1;
        tick();
        cmd_show = 1'b0;
        chk("empty_show_busy", 32'(busy), 32'd0);
        chk("empty_show_left", 32'(show_left), 32'd0);

        // Move checking
        do_check(onehot4(col[0]));
        chk("chk1_valid", 32'(result_valid), 32'd1);
        chk("chk1_result", 32'(result), 32'd1);
        chk("chk1_moves", 32'(moves_left), 32'd2);
        tick();
        chk("chk1_valid_drop", 32'(result_valid), 32'd0);
        chk("chk1_result_hold", 32'(result), 32'd1);
        do_check(4'b0000);
        chk("chk_zero_valid", 32'(result_valid), 32'd1);
        chk("chk_zero_result", 32'(result), 32'd0);
        chk("chk_zero_moves", 32'(moves_left), 32'd2);
        do_check(4'b0110);
        chk("chk_multi_valid", 32'(result_valid), 32'd1);
        chk("chk_multi_result", 32'(result), 32'd0);
        chk("chk_multi_moves", 32'(moves_left), 32'd2);
        cmd_inc_speed = 1'b1;
        do_check(onehot4(col[1]));
        cmd_inc_speed = 1'b0;
        chk("prio_valid", 32'(result_valid), 32'd0);
        chk("prio_result", 32'(result), 32'd0);
        chk("prio_moves", 32'(moves_left), 32'd2);
        do_check(onehot4(col[1]));
        chk("chk2_valid", 32'(result_valid), 32'd1);
        chk("chk2_result", 32'(result), 32'd1);
        chk("chk2_moves", 32'(moves_left), 32'd1);

        // Re-seed, freeze immediately, check with no moves left
        cmd_seed_rst = 1'b1;
        tick();
        cmd_seed_rst = 1'b0;
        chk("reseed_round", 32'(current_round), 32'd0);
        chk("reseed_moves", 32'(moves_left), 32'd0);
        chk("reseed_result", 32'(result), 32'd0);
        cmd_start_rng = 1'b1;
        tick();
        cmd_start_rng = 1'b0;
        do_check(4'b0001);
        chk("nomoves_valid", 32'(result_valid), 32'd1);
        chk("nomoves_result", 32'(result), 32'd0);
        chk("nomoves_moves", 32'(moves_left), 32'd0);

        // Fill to MAX_ROUNDS, then one append too many
        cmd_add_clr = 1'b1;
        repeat (32) tick();
        cmd_add_clr = 1'b0;
        chk("full_round", 32'(current_round), 32'd32);
        chk("full_show_left", 32'(show_left), 32'd32);
        cmd_add_clr = 1'b1;
        tick();
        cmd_add_clr = 1'b0;
        chk("over_round", 32'(current_round), 32'd32);
        chk("over_show_left", 32'(show_left), 32'd32);
        chk("over_moves", 32'(moves_left), 32'd32);
        do_check(onehot4(m0));
        chk("full_chk_result", 32'(result), 32'd1);
        chk("full_chk_moves", 32'(moves_left), 32'd31);

        // Re-seed cleared speed, so this step runs at P=16 again
        play(onehot4(m0), 16, 4, 6'd31, 1'b0);

        // Abort mid SHOW_ON
        cmd_show = 1'b1;
        tick();
        cmd_show = 1'b0;
        tick();
        tick();
        chk("abort_pre_colour", 32'(show_colour), 32'(onehot4(m1)));
        cmd_seed_rst = 1'b1;
        tick();
        cmd_seed_rst = 1'b0;
        chk("abort_colour", 32'(show_colour), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_round", 32'(current_round), 32'd0);
        chk("abort_show_left", 32'(show_left), 32'd0);
        chk("abort_moves", 32'(moves_left), 32'd0);
        for (int i = 0; i < 20; i++) begin
            chk("abort_no_pulse", 32'(pulse), 32'd0);
            tick();
        end
        cmd_start_rng = 1'b1;
        tick();
        cmd_start_rng = 1'b0;
        cmd_add_clr = 1'b1;
        tick();
        cmd_add_clr = 1'b0;
        chk("abort_seeding_round", 32'(current_round), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
